// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline sequencer: FSM states, hazard kinds and the
// bundled enable/flush control word with its per-hazard decode.
package pipe_ctrl_pkg;

   typedef enum logic {RUN, MWAIT} state_e;

   typedef enum logic [2:0] {HZ_NONE, HZ_LDUSE, HZ_RAW, HZ_BR, HZ_MEM} hz_kind_e;

   typedef struct packed {
      logic pc_en;
      logic if_id_en;
      logic id_ex_en;
      logic ex_mem_en;
      logic mem_wb_en;
      logic if_id_flush;
      logic id_ex_flush;
      logic mem_wb_flush;
   } pipe_ctrl_t;

   // Held while reset is asserted: nothing advances, every bubble inserted.
   localparam pipe_ctrl_t CTRL_RESET = 8'b00000_111;

   function automatic pipe_ctrl_t ctrl_for(hz_kind_e kind);
      pipe_ctrl_t c;
      c = '0;
      {c.pc_en, c.if_id_en, c.id_ex_en, c.ex_mem_en, c.mem_wb_en} = 5'b11111;
      case (kind)
         HZ_MEM: begin
            {c.pc_en, c.if_id_en, c.id_ex_en, c.ex_mem_en, c.mem_wb_en} = 5'b00000;
            c.mem_wb_flush = 1'b1;
         end
         HZ_BR: begin
            c.if_id_flush = 1'b1;
            c.id_ex_flush = 1'b1;
         end
         HZ_LDUSE, HZ_RAW: begin
            c.pc_en       = 1'b0;
            c.if_id_en    = 1'b0;
            c.id_ex_flush = 1'b1;
         end
         default: ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on data memory; expire_o flags that the wait
// has reached MEM_TIMEOUT.
module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic start_i,
   input  logic clear_i,
   output logic expire_o
);

   localparam int WW = $clog2(MEM_TIMEOUT + 1);

   logic [WW-1:0] wcnt_q, wcnt_d;

   assign expire_o = (wcnt_q == WW'(MEM_TIMEOUT));

   // NOTE: every path assigns wcnt_d, starting from a hold default, so no latch is inferred.
   always_comb begin
      wcnt_d = wcnt_q;
      if (clear_i)
         wcnt_d = '0;
      else if (start_i)
         wcnt_d = WW'(1);
      else if (wcnt_q != '0 && !expire_o)
         wcnt_d = wcnt_q + WW'(1);
   end

   // NOTE: state registers use non-blocking assignment so all flops update together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) wcnt_q <= '0;
      else      wcnt_q <= wcnt_d;
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline sequencer: memory freeze with watchdog, branch squash and
// RAW/load-use stalls. Define PIPE_FWD_EN when EX/MEM forwarding exists.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int RW          = 5,
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [RW-1:0] id_rs1,
   input  logic [RW-1:0] id_rs2,
   input  logic          id_rs1_use,
   input  logic          id_rs2_use,
   input  logic [RW-1:0] ex_rd,
   input  logic          ex_regwrite,
   input  logic          ex_memread,
   input  logic [RW-1:0] mem_rd,
   input  logic          mem_regwrite,
   input  logic          ex_br_taken,
   input  logic          dmem_req,
   input  logic          dmem_ack,
   output logic          pc_en,
   output logic          if_id_en,
   output logic          id_ex_en,
   output logic          ex_mem_en,
   output logic          mem_wb_en,
   output logic          if_id_flush,
   output logic          id_ex_flush,
   output logic          mem_wb_flush,
   output logic          mem_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   state_e           state_q, state_d;
   logic             mem_err_q, mem_err_d;
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
   logic             freeze, tmr_start, tmr_clear, tmr_expire;
   logic             hit_ex, load_use, data_hz;
   hz_kind_e         hz;
   pipe_ctrl_t       ctrl;

   function automatic logic src_hit(logic used, logic [RW-1:0] src, logic [RW-1:0] dst);
      return used && (src != '0) && (src == dst);
   endfunction

   assign hit_ex   = src_hit(id_rs1_use, id_rs1, ex_rd) | src_hit(id_rs2_use, id_rs2, ex_rd);
   assign load_use = ex_memread & ex_regwrite & hit_ex;

`ifdef PIPE_FWD_EN
   assign data_hz = load_use;
`else
   logic hit_mem;
   assign hit_mem = src_hit(id_rs1_use, id_rs1, mem_rd) | src_hit(id_rs2_use, id_rs2, mem_rd);
   assign data_hz = load_use | (ex_regwrite & hit_ex) | (mem_regwrite & hit_mem);
`endif

   mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .start_i  (tmr_start),
      .clear_i  (tmr_clear),
      .expire_o (tmr_expire)
   );

   // A release cycle (ack or timeout) falls through to the normal priority chain.
   always_comb begin
      state_d   = state_q;
      mem_err_d = mem_err_q;
      freeze    = 1'b0;
      tmr_start = 1'b0;
      tmr_clear = 1'b0;
      case (state_q)
         RUN: if (dmem_req && !dmem_ack) begin
            freeze    = 1'b1;
            tmr_start = 1'b1;
            state_d   = MWAIT;
         end
         MWAIT: if (dmem_ack) begin
            tmr_clear = 1'b1;
            state_d   = RUN;
         end else if (tmr_expire) begin
            tmr_clear = 1'b1;
            mem_err_d = 1'b1;
            state_d   = RUN;
         end else begin
            freeze = 1'b1;
         end
         default: state_d = RUN;
      endcase

      if (freeze)           hz = HZ_MEM;
      else if (ex_br_taken) hz = HZ_BR;
      else if (load_use)    hz = HZ_LDUSE;
      else if (data_hz)     hz = HZ_RAW;
      else                  hz = HZ_NONE;

      ctrl = rst ? ctrl_for(hz) : CTRL_RESET;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= RUN;
         mem_err_q   <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         mem_err_q <= mem_err_d;
         if ((hz == HZ_MEM || hz == HZ_LDUSE || hz == HZ_RAW) && stall_cnt_q != '1)
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         if (hz == HZ_BR && flush_cnt_q != '1)
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
   end

   assign {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, mem_wb_flush} = ctrl;
   assign mem_err   = mem_err_q;
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed and random checks of pipe_hazard_ctrl against a cycle-level
// behavioural model of the pipeline control rules.
module tb_pipe_hazard_ctrl;

   localparam int RW          = 5;
   localparam int MEM_TIMEOUT = 16;
   localparam int CNT_W       = 6;
   localparam int CNT_MAX     = (1 << CNT_W) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic [RW-1:0] id_rs1, id_rs2, ex_rd, mem_rd;
   logic          id_rs1_use, id_rs2_use, ex_regwrite, ex_memread, mem_regwrite;
   logic          ex_br_taken, dmem_req, dmem_ack;
   logic          pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
   logic          if_id_flush, id_ex_flush, mem_wb_flush, mem_err;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;
   logic [7:0]    ctrl_o;

   int vectors     = 0;
   int miscompares = 0;

   // Model state: inside a memory wait, how many frozen cycles so far, sticky error, counts.
   bit m_inwait;
   int m_frozen;
   bit m_err;
   int m_stall, m_flush;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.RW(RW), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_use(id_rs1_use), .id_rs2_use(id_rs2_use),
      .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
      .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
      .ex_br_taken(ex_br_taken), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
      .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
      .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
      .mem_wb_flush(mem_wb_flush), .mem_err(mem_err),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   assign ctrl_o = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                    if_id_flush, id_ex_flush, mem_wb_flush};

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit depends_on(logic [RW-1:0] r);
      return (id_rs1_use && id_rs1 != 0 && id_rs1 == r) ||
             (id_rs2_use && id_rs2 != 0 && id_rs2 == r);
   endfunction

   task automatic idle();
      {id_rs1, id_rs2, ex_rd, mem_rd} = '0;
      {id_rs1_use, id_rs2_use, ex_regwrite, ex_memread, mem_regwrite} = '0;
      {ex_br_taken, dmem_req, dmem_ack} = '0;
   endtask

   // Check one cycle's outputs against the model, then advance model and clock.
   task automatic step(string tag);
      bit frozen, timeout, ld, raw, stall;
      logic [7:0] exp;
      #1;
      frozen  = 0;
      timeout = 0;
      if (!m_inwait)
         frozen = dmem_req && !dmem_ack;
      else if (!dmem_ack) begin
         if (m_frozen >= MEM_TIMEOUT) timeout = 1;
         else                         frozen  = 1;
      end
      ld  = ex_memread && ex_regwrite && depends_on(ex_rd);
`ifdef PIPE_FWD_EN
      raw = 0;
`else
      raw = (ex_regwrite && depends_on(ex_rd)) || (mem_regwrite && depends_on(mem_rd));
`endif
      stall = 0;
      if (frozen)           begin exp = 8'b00000_001; stall = 1; end
      else if (ex_br_taken) begin exp = 8'b11111_110; if (m_flush < CNT_MAX) m_flush++; end
      else if (ld || raw)   begin exp = 8'b00111_010; stall = 1; end
      else                        exp = 8'b11111_000;

      check({tag, "_ctrl"}, ctrl_o, exp);
      check({tag, "_stall_cnt"}, stall_cnt, m_stall);
      check({tag, "_flush_cnt"}, flush_cnt, (ex_br_taken && !frozen) ? m_flush - 1 : m_flush);
      check({tag, "_mem_err"}, mem_err, m_err);

      if (stall && m_stall < CNT_MAX) m_stall++;
      if (frozen) begin
         if (m_inwait) m_frozen++;
         else begin m_inwait = 1; m_frozen = 1; end
      end else begin
         if (timeout) m_err = 1;
         m_inwait = 0;
         m_frozen = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(string tag);
      rst = 1'b0;
      #1;
      check({tag, "_rst_ctrl"}, ctrl_o, 8'b00000_111);
      check({tag, "_rst_stall"}, stall_cnt, 0);
      check({tag, "_rst_flush"}, flush_cnt, 0);
      check({tag, "_rst_err"}, mem_err, 0);
      m_inwait = 0; m_frozen = 0; m_err = 0; m_stall = 0; m_flush = 0;
      @(posedge clk);
      #1;
      check({tag, "_rst_hold"}, ctrl_o, 8'b00000_111);
      idle();
      rst = 1'b1;
   endtask

   initial begin
      idle();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      do_reset("init");

      // Load-use: one bubble then flow.
      ex_memread = 1; ex_regwrite = 1; ex_rd = 3; id_rs1 = 3; id_rs1_use = 1;
      step("t2_lduse");
      idle();
      step("t2_after");
      check("t2_cnt", stall_cnt, 1);

      // Destination x0 never creates a hazard.
      ex_memread = 1; ex_regwrite = 1; ex_rd = 0; id_rs2 = 0; id_rs2_use = 1;
      step("t3_x0");
      idle();

      // Branch beats simultaneous load-use.
      do_reset("t4");
      ex_memread = 1; ex_regwrite = 1; ex_rd = 9; id_rs1 = 9; id_rs1_use = 1; ex_br_taken = 1;
      step("t4_br_ld");
      idle();
      step("t4_after");
      check("t4_flush_cnt", flush_cnt, 1);
      check("t4_stall_cnt", stall_cnt, 0);

      // ALU RAW through EX then MEM.
      do_reset("t6");
      ex_regwrite = 1; ex_rd = 7; id_rs1 = 7; id_rs1_use = 1;
      step("t6_ex");
      ex_regwrite = 0; ex_rd = 0; mem_regwrite = 1; mem_rd = 7;
      step("t6_mem");
      idle();
      step("t6_after");
`ifdef PIPE_FWD_EN
      check("t6_cnt", stall_cnt, 0);
`else
      check("t6_cnt", stall_cnt, 2);
`endif

      // Memory wait released by ack on the fifth cycle.
      do_reset("t5a");
      dmem_req = 1;
      repeat (4) step("t5a_wait");
      dmem_ack = 1;
      step("t5a_ack");
      idle();
      step("t5a_after");
      check("t5a_err", mem_err, 0);

      // No ack: watchdog releases, branch held during the wait is seen on release.
      dmem_req = 1; ex_br_taken = 1;
      for (int i = 0; i < MEM_TIMEOUT; i++) step("t5b_wait");
      step("t5b_release");
      idle();
      repeat (3) step("t5b_after");
      check("t5b_err_sticky", mem_err, 1);

      // Reset mid-wait clears everything, including the sticky error.
      dmem_req = 1;
      repeat (5) step("t1_wait");
      do_reset("t1");
      step("t1_run");

      // Random traffic, small register space to make dependencies common.
      do_reset("rnd");
      for (int i = 0; i < 500; i++) begin
         id_rs1       = RW'($urandom_range(0, 3));
         id_rs2       = RW'($urandom_range(0, 3));
         ex_rd        = RW'($urandom_range(0, 3));
         mem_rd       = RW'($urandom_range(0, 3));
         id_rs1_use   = 1'($urandom_range(0, 1));
         id_rs2_use   = 1'($urandom_range(0, 1));
         ex_regwrite  = 1'($urandom_range(0, 1));
         ex_memread   = 1'($urandom_range(0, 1));
         mem_regwrite = 1'($urandom_range(0, 1));
         ex_br_taken  = ($urandom_range(0, 7) == 0);
         dmem_req     = ($urandom_range(0, 5) == 0);
         dmem_ack     = ($urandom_range(0, 4) == 0);
         step("rnd");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
